// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants so RX, RX FIFO and TX FIFO agree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_DATA_LENGTH      = 8;
    localparam int c_FIFO_DEPTH       = 16;
    localparam int c_FIFO_ALMOST_FULL = 12;

    // Pointer carries one extra wrap bit above the storage address.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Write/read handshake and status bundle of the RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = c_DATA_LENGTH,
    parameter int DEPTH       = c_FIFO_DEPTH
);

    localparam int c_CNT_W = fifo_ptr_width(DEPTH);

    logic                   i_wr_en;
    logic [DATA_LENGTH-1:0] i_wr_data;
    logic                   i_rd_en;
    logic                   i_overflow_clr;
    logic [DATA_LENGTH-1:0] o_rd_data;
    logic                   o_rd_valid;
    logic                   o_empty;
    logic                   o_full;
    logic                   o_almost_full;
    logic [c_CNT_W-1:0]     o_count;
    logic                   o_overflow;

    modport master (
        output i_wr_en, i_wr_data, i_rd_en, i_overflow_clr,
        input  o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full,
               o_count, o_overflow
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en, i_overflow_clr,
        output o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full,
               o_count, o_overflow
    );

endinterface : uart_rx_fifo_if

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// Module      : uart_fifo_mem
// Description : Simple dual-port register array with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = c_DATA_LENGTH,
    parameter int DEPTH       = c_FIFO_DEPTH,
    localparam int c_AW       = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [c_AW-1:0]        i_wr_addr,
    input  logic [DATA_LENGTH-1:0] i_wr_data,
    input  logic                   i_rd_en,
    input  logic [c_AW-1:0]        i_rd_addr,
    output logic [DATA_LENGTH-1:0] o_rd_data
);

    logic [DATA_LENGTH-1:0] r_mem [DEPTH];
    logic [DATA_LENGTH-1:0] r_rd_data;

    // Storage is intentionally unreset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write: a same-address write this cycle is not seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : uart_fifo_mem

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive FIFO with occupancy, status and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH       = c_DATA_LENGTH,
    parameter int DEPTH             = c_FIFO_DEPTH,
    parameter int ALMOST_FULL_LEVEL = c_FIFO_ALMOST_FULL
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    uart_rx_fifo_if.slave  bus
);

    localparam int            c_PW      = fifo_ptr_width(DEPTH);
    localparam int            c_AW      = c_PW - 1;
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_PW-1:0] c_AF_LVL  = c_PW'(ALMOST_FULL_LEVEL);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > DEPTH)) begin : g_bad_params
            $error("uart_rx_fifo: illegal DEPTH or ALMOST_FULL_LEVEL");
        end
    endgenerate

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            r_rd_valid;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_do_rd;
    logic            w_do_wr;
    logic            w_ovf_set;
    logic [c_PW-1:0] w_count;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    // A read while full frees the slot the same cycle, so the write still lands.
    assign w_do_rd   = bus.i_rd_en && !w_empty;
    assign w_do_wr   = bus.i_wr_en && (!w_full || bus.i_rd_en);
    assign w_ovf_set = bus.i_wr_en && w_full && !bus.i_rd_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_rd_valid <= w_do_rd;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.i_overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_LENGTH (DATA_LENGTH),
        .DEPTH       (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_do_wr),
        .i_wr_addr (r_wr_ptr[c_AW-1:0]),
        .i_wr_data (bus.i_wr_data),
        .i_rd_en   (w_do_rd),
        .i_rd_addr (r_rd_ptr[c_AW-1:0]),
        .o_rd_data (bus.o_rd_data)
    );

    assign bus.o_rd_valid    = r_rd_valid;
    assign bus.o_empty       = w_empty;
    assign bus.o_full        = w_full;
    assign bus.o_almost_full = (w_count >= c_AF_LVL);
    assign bus.o_count       = w_count;
    assign bus.o_overflow    = r_overflow;

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_LENGTH(DW), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_LENGTH       (DW),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data  = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_ovf      = 1'b0;

    // One clock of stimulus; the model applies the FIFO rules at the edge.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        int sz;
        bit do_rd, do_wr, full, empty;
        bus.i_wr_en        = wr;
        bus.i_wr_data      = d;
        bus.i_rd_en        = rd;
        bus.i_overflow_clr = clr;
        @(posedge clk);
        sz    = q.size();
        full  = (sz == DEPTH);
        empty = (sz == 0);
        do_rd = rd && !empty;
        do_wr = wr && (!full || rd);
        if (do_rd) m_rd_data = q.pop_front();
        m_rd_valid = do_rd;
        if (do_wr) q.push_back(d);
        if (wr && full && !rd) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        bus.i_wr_en        = 1'b0;
        bus.i_rd_en        = 1'b0;
        bus.i_overflow_clr = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_wr_en = 0; bus.i_wr_data = '0; bus.i_rd_en = 0; bus.i_overflow_clr = 0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 ||
            bus.o_almost_full !== 1'b0 || bus.o_rd_data !== 8'h00 ||
            bus.o_rd_valid !== 1'b0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got cnt=%0d emp=%b full=%b af=%b data=%h vld=%b ovf=%b want 0 1 0 0 00 0 0",
                     bus.o_count, bus.o_empty, bus.o_full, bus.o_almost_full,
                     bus.o_rd_data, bus.o_rd_valid, bus.o_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete(); m_rd_data = '0; m_rd_valid = 0; m_ovf = 0;
    endtask

    task automatic test_basic();
        logic [4:0]    exp_cnt [4] = '{5'd1, 5'd2, 5'd1, 5'd0};
        logic [DW-1:0] exp_dat [2] = '{8'hA5, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) step(1'b1, exp_dat[i], 1'b0, 1'b0);
            else       step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (bus.o_count !== exp_cnt[i]) begin
                errors++;
                $display("FAIL basic_count[%0d] got %0d want %0d", i, bus.o_count, exp_cnt[i]);
            end
            checks++;
            if (bus.o_rd_valid !== (i >= 2)) begin
                errors++;
                $display("FAIL basic_valid[%0d] got %b want %b", i, bus.o_rd_valid, (i >= 2));
            end
            if (i >= 2) begin
                checks++;
                if (bus.o_rd_data !== exp_dat[i-2]) begin
                    errors++;
                    $display("FAIL basic_data[%0d] got %h want %h", i, bus.o_rd_data, exp_dat[i-2]);
                end
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.o_empty !== 1'b1 || bus.o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got emp=%b vld=%b want 1 0", bus.o_empty, bus.o_rd_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (bus.o_count !== 5'(i + 1) || bus.o_almost_full !== (i + 1 >= AFL) ||
                bus.o_full !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL fill[%0d] got cnt=%0d af=%b full=%b want %0d %b %b", i,
                         bus.o_count, bus.o_almost_full, bus.o_full, i + 1, (i + 1 >= AFL), (i == DEPTH - 1));
            end
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_set got ovf=%b cnt=%0d want 1 16", bus.o_overflow, bus.o_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 8'(i)) begin
                errors++;
                $display("FAIL drain[%0d] got vld=%b data=%h want 1 %h", i, bus.o_rd_valid, bus.o_rd_data, 8'(i));
            end
        end
        checks++;
        if (bus.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got %b want 1", bus.o_empty);
        end
    endtask

    task automatic test_overflow_clr();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.o_overflow);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_reset got %b want 1", bus.o_overflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h66, 1'b0, 1'b1);
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins got %b want 1", bus.o_overflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_simul_full();
        step(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 8'h10 || bus.o_count !== 5'd16 ||
            bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_rw got vld=%b data=%h cnt=%0d ovf=%b want 1 10 16 0",
                     bus.o_rd_valid, bus.o_rd_data, bus.o_count, bus.o_overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (bus.o_rd_data !== ((i == DEPTH - 1) ? 8'h77 : 8'(8'h11 + i))) begin
                errors++;
                $display("FAIL full_rw_order[%0d] got %h want %h", i, bus.o_rd_data,
                         (i == DEPTH - 1) ? 8'h77 : 8'(8'h11 + i));
            end
        end
    endtask

    task automatic test_empty_read();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== 8'h77 || bus.o_count !== 5'd0) begin
            errors++;
            $display("FAIL empty_read got vld=%b data=%h cnt=%0d want 0 77 0",
                     bus.o_rd_valid, bus.o_rd_data, bus.o_count);
        end
        step(1'b1, 8'h42, 1'b1, 1'b0);
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_count !== 5'd1 || bus.o_rd_data !== 8'h77) begin
            errors++;
            $display("FAIL empty_rw got vld=%b cnt=%0d data=%h want 0 1 77",
                     bus.o_rd_valid, bus.o_count, bus.o_rd_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 8'h42) begin
            errors++;
            $display("FAIL empty_rw_read got vld=%b data=%h want 1 42", bus.o_rd_valid, bus.o_rd_data);
        end
    endtask

    task automatic test_wrap();
        logic wr, rd;
        for (int i = 0; i < 200; i++) begin
            wr = ($urandom_range(0, 99) < 55) && (q.size() < 5);
            rd = ($urandom_range(0, 99) < 50);
            step(wr, 8'($urandom), rd, 1'b0);
            checks++;
            if (bus.o_count !== 5'(q.size()) || bus.o_rd_valid !== m_rd_valid ||
                bus.o_rd_data !== m_rd_data) begin
                errors++;
                $display("FAIL wrap[%0d] got cnt=%0d vld=%b data=%h want %0d %b %h", i,
                         bus.o_count, bus.o_rd_valid, bus.o_rd_data, q.size(), m_rd_valid, m_rd_data);
            end
        end
    endtask

    task automatic test_random();
        logic wr, rd, clr;
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom_range(0, 99) < 60);
            rd  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 99) < 6);
            step(wr, 8'($urandom), rd, clr);
            checks++;
            if (bus.o_count !== 5'(q.size()) || bus.o_empty !== (q.size() == 0) ||
                bus.o_full !== (q.size() == DEPTH) || bus.o_almost_full !== (q.size() >= AFL) ||
                bus.o_overflow !== m_ovf || bus.o_rd_valid !== m_rd_valid ||
                bus.o_rd_data !== m_rd_data) begin
                errors++;
                $display("FAIL random[%0d] got cnt=%0d e=%b f=%b af=%b ovf=%b vld=%b d=%h want cnt=%0d ovf=%b vld=%b d=%h",
                         i, bus.o_count, bus.o_empty, bus.o_full, bus.o_almost_full, bus.o_overflow,
                         bus.o_rd_valid, bus.o_rd_data, q.size(), m_ovf, m_rd_valid, m_rd_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        if (q.size() == 0) step(1'b1, 8'h11, 1'b0, 1'b0);
        // Leave a read pulse in flight and a non-zero count, then drop reset between edges.
        step(1'b1, 8'hE7, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 ||
            bus.o_almost_full !== 1'b0 || bus.o_rd_data !== 8'h00 ||
            bus.o_rd_valid !== 1'b0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got cnt=%0d emp=%b full=%b af=%b data=%h vld=%b ovf=%b want 0 1 0 0 00 0 0",
                     bus.o_count, bus.o_empty, bus.o_full, bus.o_almost_full,
                     bus.o_rd_data, bus.o_rd_valid, bus.o_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete(); m_rd_data = '0; m_rd_valid = 0; m_ovf = 0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_after got vld=%b cnt=%0d want 0 0", bus.o_rd_valid, bus.o_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_overflow_clr();
        test_simul_full();
        test_empty_read();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo

`default_nettype wire
